// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64M multiply/divide unit, 64-cycle fixed latency
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write
);

    localparam logic [2:0] F_MUL  = 3'b000;
    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    localparam logic [5:0]      ITER_LAST = 6'd63;
    localparam logic [XLEN-1:0] ALL_ONES  = '1;
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [5:0]      cnt;
    logic [2:0]      op_q;
    // a_q: multiplier (MUL) or dividend shifting into quotient (divide)
    // b_q: multiplicand (MUL) or divisor (divide)
    // acc_q: product accumulator (MUL) or partial remainder (divide)
    logic [XLEN-1:0] a_q, b_q, acc_q;
    logic            q_neg, r_neg, div0_q, ovf_q;

    logic            start_sdiv;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN-1:0] mul_acc, mul_a, mul_b;
    logic [XLEN:0]   div_shift, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_rem, div_q;
    logic [XLEN-1:0] a_nxt, b_nxt, acc_nxt;
    logic [XLEN-1:0] quot_signed, rem_signed, result_nxt;

    // Operand magnitudes and special-case detection for the start cycle
    always_comb begin
        start_sdiv = (funct3 == F_DIV) || (funct3 == F_REM);
        a_mag      = (start_sdiv && op_a[XLEN-1]) ? (~op_a + 1'b1) : op_a;
        b_mag      = (start_sdiv && op_b[XLEN-1]) ? (~op_b + 1'b1) : op_b;
    end

    // One shift-add or restoring-divide step, plus the result that step would finalise
    always_comb begin
        mul_acc   = acc_q + (a_q[0] ? b_q : '0);
        mul_a     = a_q >> 1;
        mul_b     = b_q << 1;

        // Partial remainder is always below the divisor, so the 65-bit shifted
        // value is the only place the extra bit is needed.
        div_shift = {acc_q, a_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[XLEN];
        div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_q     = {a_q[XLEN-2:0], div_ge};

        if (op_q == F_MUL) begin
            a_nxt   = mul_a;
            b_nxt   = mul_b;
            acc_nxt = mul_acc;
        end else begin
            a_nxt   = div_q;
            b_nxt   = b_q;
            acc_nxt = div_rem;
        end

        quot_signed = q_neg ? (~div_q + 1'b1) : div_q;
        rem_signed  = r_neg ? (~div_rem + 1'b1) : div_rem;

        // Remainder of a divide by zero falls out of the datapath as the
        // re-signed dividend magnitude, i.e. the original op_a.
        case (op_q)
            F_MUL:   result_nxt = mul_acc;
            F_DIV:   result_nxt = ovf_q ? INT_MIN : (div0_q ? ALL_ONES : quot_signed);
            F_DIVU:  result_nxt = div0_q ? ALL_ONES : div_q;
            F_REM:   result_nxt = ovf_q ? '0 : rem_signed;
            F_REMU:  result_nxt = div_rem;
            default: result_nxt = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (cnt == ITER_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        reg_write = done && (rd_out != 5'd0);
    end

    // Operand latch at start, iteration datapath, and result load on the last step
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        op_q   <= funct3;
                        rd_out <= rd_in;
                        a_q    <= a_mag;
                        b_q    <= b_mag;
                        acc_q  <= '0;
                        q_neg  <= start_sdiv && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        r_neg  <= start_sdiv && op_a[XLEN-1];
                        div0_q <= (op_b == '0);
                        ovf_q  <= start_sdiv && (op_a == INT_MIN) && (op_b == ALL_ONES);
                    end
                end
                ITER: begin
                    a_q   <= a_nxt;
                    b_q   <= b_nxt;
                    acc_q <= acc_nxt;
                    cnt   <= cnt + 6'd1;
                    if (cnt == ITER_LAST) begin
                        result <= result_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - table-driven scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, reg_write;
    logic [63:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    logic prev_done = 1'b0;

    muldiv_unit #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out),
        .reg_write (reg_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (done) begin
            check("busy_with_done", {63'd0, busy}, 64'd0);
            check("done_repeat", {63'd0, prev_done}, 64'd0);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: result %h rd %0d", result, rd_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_result", result, e.res);
                check("sb_rd_out", {59'd0, rd_out}, {59'd0, e.rd});
                check("sb_reg_write", {63'd0, reg_write}, {63'd0, e.we});
            end
        end
        prev_done = done;
    end

    // Issue one op from IDLE, check busy through cycles 1-64 and done at 65; returns in cycle 66
    task automatic run_op(input string nm, input logic [2:0] f, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp);
        int   lat;
        logic busy_gap;
        exp_t e;
        e.res = exp;
        e.rd  = rd;
        e.we  = (rd != 5'd0);
        sb_q.push_back(e);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        step();
        start  = 1'b0;
        op_a   = {$urandom, $urandom};
        op_b   = {$urandom, $urandom};
        rd_in  = 5'($urandom);
        funct3 = 3'($urandom);
        check({nm, "_busy_c1"}, {63'd0, busy}, 64'd1);
        lat      = 1;
        busy_gap = 1'b0;
        while (!done && lat < 200) begin
            if (!busy) busy_gap = 1'b1;
            step();
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'd65);
        check({nm, "_busy_gap"}, {63'd0, busy_gap}, 64'd0);
        step();
    endtask

    initial begin
        int   c;
        exp_t e;

        vecs.push_back('{3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB});
        vecs.push_back('{3'b100, -64'sd20, 64'd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFFA});
        vecs.push_back('{3'b110, -64'sd20, 64'd3, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{3'b101, 64'd100, 64'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{3'b111, 64'd100, 64'd0, 5'd4, 64'd100});
        vecs.push_back('{3'b100, 64'd100, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'h8000_0000_0000_0000});
        vecs.push_back('{3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'd0});
        vecs.push_back('{3'b101, 64'd1000, 64'd7, 5'd9, 64'd142});
        vecs.push_back('{3'b111, 64'd1000, 64'd7, 5'd10, 64'd6});
        vecs.push_back('{3'b001, 64'd55, 64'd66, 5'd11, 64'd0});
        vecs.push_back('{3'b000, 64'h1234_5678_9ABC_DEF0, 64'h10, 5'd12, 64'h2345_6789_ABCD_EF00});
        vecs.push_back('{3'b100, 64'd20, -64'sd3, 5'd13, 64'hFFFF_FFFF_FFFF_FFFA});
        vecs.push_back('{3'b110, 64'd20, -64'sd3, 5'd14, 64'd2});
        vecs.push_back('{3'b110, -64'sd20, -64'sd3, 5'd15, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd16, 64'h7FFF_FFFF_FFFF_FFFF});
        vecs.push_back('{3'b110, -64'sd5, 64'd0, 5'd17, 64'hFFFF_FFFF_FFFF_FFFB});

        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (3) step();
        reset = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_reg_write", {63'd0, reg_write}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_rd_out", {59'd0, rd_out}, 64'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("v%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
        end

        // Abort: DIVU 1000/7 started at cycle 0, reset (with start) at cycle 30
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 64'd1000;
        op_b   = 64'd7;
        rd_in  = 5'd3;
        step();
        start = 1'b0;
        repeat (29) step();
        check("abort_busy_c30", {63'd0, busy}, 64'd1);
        reset  = 1'b1;
        start  = 1'b1;
        funct3 = 3'b000;
        step();
        reset = 1'b0;
        start = 1'b0;
        check("abort_busy_c31", {63'd0, busy}, 64'd0);
        check("abort_done_c31", {63'd0, done}, 64'd0);
        check("abort_result_c31", result, 64'd0);
        check("abort_rd_out_c31", {59'd0, rd_out}, 64'd0);
        step();
        check("abort_idle_c32", {63'd0, busy}, 64'd0);

        // Restart at cycle 32; a second start at cycle 40 must be ignored
        e.res = 64'd142;
        e.rd  = 5'd9;
        e.we  = 1'b1;
        sb_q.push_back(e);
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 64'd1000;
        op_b   = 64'd7;
        rd_in  = 5'd9;
        step();
        start = 1'b0;
        c = 33;
        repeat (7) begin
            step();
            c++;
        end
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 64'd5;
        op_b   = 64'd5;
        rd_in  = 5'd4;
        step();
        c++;
        start = 1'b0;
        while (!done && c < 300) begin
            step();
            c++;
        end
        check("restart_done_cycle", 64'(c), 64'd97);
        step();
        step();
        check("ignored_start_idle", {63'd0, busy}, 64'd0);

        // x0 destination, then an immediate back-to-back start
        run_op("x0_mul", 3'b000, 64'd3, 64'd4, 5'd0, 64'd12);
        run_op("b2b_mul", 3'b000, 64'd6, 64'd7, 5'd20, 64'd42);

        repeat (3) step();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
